ram_rmw_ctrl: RTL and testbench
===============================

RAM_RMW_CTRL -- requirements
Module: ram_rmw_ctrl

Interface
REQ-001 Parameter: DEPTH, default 256, number of 64-bit words in the attached SRAM (power of two, 2..65536).
REQ-002 Parameter: AW, default 8, SRAM address width; SHALL equal log2(DEPTH).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  the single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 ram_re  in  1  CPU read request.
REQ-007 ram_we  in  1  CPU write request.
REQ-008 ram_addr  in  28  CPU 64-bit word address.
REQ-009 ram_dout  in  64  CPU write data (CPU-to-memory).
REQ-010 ram_mask  in  8  byte enables; bit i selects ram_dout[8i+7:8i].
REQ-011 ram_din  out  64  read data to CPU.
REQ-012 ram_ready  out  1  high = idle and accepting; low = busy.
REQ-013 ram_err  out  1  one-cycle pulse: the completing access was out of range.
REQ-014 sram_en  out  1  SRAM access strobe.
REQ-015 sram_we  out  1  SRAM write (valid with sram_en).
REQ-016 sram_addr  out  AW  SRAM word address.
REQ-017 sram_wdata  out  64  SRAM write data.
REQ-018 sram_rdata  in  64  SRAM read data, valid the cycle after the edge that samples sram_en=1, sram_we=0.

Function
REQ-019 Block converts CPU byte-masked 64-bit requests into whole-word SRAM accesses; partial writes use read-modify-write.
REQ-020 FSM states: IDLE, RD, RD_CAP, RMW_RD, RMW_MRG, WR.
REQ-021 Request accepted on rising edge where state=IDLE and (ram_re or ram_we); ram_addr, ram_dout, ram_mask registered at that edge.
REQ-022 ram_re and ram_we both high: read taken, write dropped.
REQ-023 Requests while ram_ready=0 ignored; no queuing.
REQ-024 ram_ready SHALL be 1 exactly when state=IDLE.
REQ-025 Read: IDLE->RD (sram_en=1, sram_we=0) ->RD_CAP (capture sram_rdata) ->IDLE; ram_ready low 2 cycles; ram_din valid from ram_ready rise.
REQ-026 ram_din holds last read data until next read completes; writes never change it.
REQ-027 Write, ram_mask=8'hFF: IDLE->WR (sram_en=1, sram_we=1, sram_wdata=ram_dout) ->IDLE; ram_ready low 1 cycle.
REQ-028 Write, mask partial (not 00, not FF): IDLE->RMW_RD->RMW_MRG->WR->IDLE; merged byte i = mask[i] ? wdata byte i : sram_rdata byte i; ram_ready low 3 cycles.
REQ-029 Write, ram_mask=8'h00: IDLE->WR with sram_en=0 (no SRAM access) ->IDLE; ram_ready low 1 cycle.
REQ-030 Out of range (ram_addr >= DEPTH): no SRAM access in any state; read follows RD/RD_CAP timing and returns 64'hFFFF_FFFF_FFFF_FFFF; write follows WR timing, discarded.
REQ-031 ram_err pulses high during the first ram_ready=1 cycle after an out-of-range access; low otherwise.
REQ-032 sram_addr = registered ram_addr[AW-1:0]; sram_en=0 and sram_we=0 in IDLE.
REQ-033 No request captured on the edge that returns FSM to IDLE; earliest next acceptance is the following edge.

Reset
REQ-034 rst=0 forces immediately: state=IDLE, ram_ready=1, ram_din=0, ram_err=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
REQ-035 Reset mid-operation aborts access; in-flight RMW SHALL NOT write SRAM after reset asserts.
REQ-036 First acceptance possible on first rising edge with rst=1.

Verification
REQ-037 Preload word 5 = 64'h0011223344556677; read addr 5 -> ram_ready low 2 cycles, then ram_din=64'h0011223344556677, ram_err=0.
REQ-038 Write addr 3, mask FF, data 64'hDEADBEEFCAFEF00D -> one sram_we cycle, ready low 1 cycle; read 3 returns same.
REQ-039 Word 7 = 64'h1111111111111111; write addr 7, mask 8'h0F, data 64'hAAAAAAAABBBBBBBB -> ready low 3 cycles; read 7 = 64'h11111111BBBBBBBB.
REQ-040 Read addr 300 (DEPTH=256) -> no sram_en, ram_din=64'hFFFFFFFFFFFFFFFF, ram_err one-cycle pulse; write addr 300 -> SRAM unchanged.
REQ-041 ram_re and ram_we both high, addr 5 -> read performed, word 5 unchanged; write with mask 00 -> no sram_en, ready low 1 cycle.
REQ-042 Assert rst during RMW_MRG of partial write to addr 9 -> no SRAM write, all outputs at reset values, word 9 unchanged.

Source files
------------

// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl: bridges byte-masked 64-bit CPU requests onto a word-only
// SRAM. Partial writes are done as read-modify-write; out-of-range requests
// keep their normal timing, never touch the SRAM, and raise a one-cycle error.
module ram_rmw_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ram_re,
  input  logic          ram_we,
  input  logic [27:0]   ram_addr,
  input  logic [63:0]   ram_dout,
  input  logic [7:0]    ram_mask,
  output logic [63:0]   ram_din,
  output logic          ram_ready,
  output logic          ram_err,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [63:0]   sram_wdata,
  input  logic [63:0]   sram_rdata
);

  localparam int DATA_W = 64;
  localparam int BYTES  = DATA_W / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_CAP  = 3'd2;
  localparam logic [2:0] S_RMW_RD  = 3'd3;
  localparam logic [2:0] S_RMW_MRG = 3'd4;
  localparam logic [2:0] S_WR      = 3'd5;

  logic [2:0]        state;
  logic [AW-1:0]     addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [BYTES-1:0]  mask_p0;
  logic              in_range_p0;
  logic              wr_en_p0;
  logic [DATA_W-1:0] din_q;
  logic              err_q;
  logic              req_in_range;
  logic              req_partial;

  // Byte-wise merge: enabled bytes come from the CPU, the rest from the SRAM.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] rdata,
    input logic [BYTES-1:0]  mask
  );
    logic [DATA_W-1:0] res;
    res = rdata;
    for (int i = 0; i < BYTES; i++) begin
      if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign req_in_range = 32'(ram_addr) < DEPTH;
  assign req_partial  = (ram_mask != 8'h00) && (ram_mask != 8'hFF);

  // Request capture, sequencing, read-data and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr_p0     <= '0;
      wdata_p0    <= '0;
      mask_p0     <= '0;
      in_range_p0 <= 1'b0;
      wr_en_p0    <= 1'b0;
      din_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (ram_re || ram_we) begin
            addr_p0     <= ram_addr[AW-1:0];
            wdata_p0    <= ram_dout;
            mask_p0     <= ram_mask;
            in_range_p0 <= req_in_range;
            wr_en_p0    <= (ram_mask != 8'h00);
            if (ram_re)                            state <= S_RD;
            else if (req_in_range && req_partial)  state <= S_RMW_RD;
            else                                   state <= S_WR;
          end
        end
        S_RD:      state <= S_RD_CAP;
        S_RD_CAP: begin
          din_q <= in_range_p0 ? sram_rdata : {DATA_W{1'b1}};
          err_q <= !in_range_p0;
          state <= S_IDLE;
        end
        S_RMW_RD:  state <= S_RMW_MRG;
        S_RMW_MRG: begin
          wdata_p0 <= merge_bytes(wdata_p0, sram_rdata, mask_p0);
          state    <= S_WR;
        end
        S_WR: begin
          err_q <= !in_range_p0;
          state <= S_IDLE;
        end
        default:   state <= S_IDLE;
      endcase
    end
  end

  // SRAM strobes follow the state; out-of-range and empty-mask accesses are gated off.
  always_comb begin
    sram_en = 1'b0;
    sram_we = 1'b0;
    if (in_range_p0) begin
      case (state)
        S_RD, S_RMW_RD: sram_en = 1'b1;
        S_WR: begin
          sram_en = wr_en_p0;
          sram_we = wr_en_p0;
        end
        default: sram_en = 1'b0;
      endcase
    end
  end

  assign sram_addr  = addr_p0;
  assign sram_wdata = wdata_p0;
  assign ram_din    = din_q;
  assign ram_err    = err_q;
  assign ram_ready  = (state == S_IDLE);

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Testbench for ram_rmw_ctrl: behavioural SRAM, reference memory model,
// scoreboard queue filled by the stimulus and drained by a completion monitor.
module tb_ram_rmw_ctrl;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_re, ram_we;
  logic [27:0]   ram_addr;
  logic [63:0]   ram_dout;
  logic [7:0]    ram_mask;
  logic [63:0]   ram_din;
  logic          ram_ready, ram_err;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [63:0]   sram_wdata, sram_rdata;

  ram_rmw_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ram_re(ram_re), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_mask(ram_mask),
    .ram_din(ram_din), .ram_ready(ram_ready), .ram_err(ram_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with a preload port for the bench.
  logic [63:0]   sram_mem [DEPTH];
  logic [63:0]   rdata_q = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [63:0]   pl_data;
  always @(posedge clk) begin
    if (pl_en) sram_mem[pl_addr] <= pl_data;
    else if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         rdata_q <= sram_mem[sram_addr];
    end
  end
  assign sram_rdata = rdata_q;

  // Reference model state
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] last_din;

  typedef struct {
    logic [63:0] din;
    bit          err;
    int          busy;
    int          en;
    int          we;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  function automatic void fail_note(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
  endfunction

  // Completion monitor: samples on the falling edge, pops one expectation per ready rise.
  int busy_cnt = 0, en_cnt = 0, we_cnt = 0;
  bit prev_ready = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      busy_cnt = 0; en_cnt = 0; we_cnt = 0;
      prev_ready = 1'b1;
    end else begin
      if (!ram_ready) begin
        busy_cnt = busy_cnt + 1;
        en_cnt   = en_cnt + (sram_en ? 1 : 0);
        we_cnt   = we_cnt + ((sram_en && sram_we) ? 1 : 0);
      end else if (!prev_ready) begin
        if (exp_q.size() == 0) fail_note("unexpected_completion");
        else begin
          e = exp_q.pop_front();
          chk("din",  ram_din, e.din);
          chk("err",  64'(ram_err), 64'(e.err));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          chk("sram_en_cycles", 64'(en_cnt), 64'(e.en));
          chk("sram_we_cycles", 64'(we_cnt), 64'(e.we));
        end
        busy_cnt = 0; en_cnt = 0; we_cnt = 0;
      end else begin
        chk("err_idle", 64'(ram_err), 64'd0);
        chk("sram_en_idle", 64'(sram_en), 64'd0);
      end
      prev_ready = ram_ready;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ram_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        fail_note("ready_timeout");
        break;
      end
    end
  endtask

  // Issue one request, push its expected outcome, optionally hold a junk request while busy.
  task automatic do_op(input bit re, input bit we, input logic [27:0] addr,
                       input logic [63:0] data, input logic [7:0] mask, input bit junk);
    exp_t e;
    bit oor;
    logic [63:0] m64;
    logic [AW-1:0] a;
    oor = ({4'b0, addr} >= 32'(DEPTH));
    a   = addr[AW-1:0];
    wait_ready();
    if (re) begin
      e.busy = 2;
      e.en   = oor ? 0 : 1;
      e.we   = 0;
      e.din  = oor ? 64'hFFFF_FFFF_FFFF_FFFF : ref_mem[a];
      e.err  = oor;
      last_din = e.din;
    end else begin
      e.err = oor;
      e.din = last_din;
      if (oor || mask == 8'h00) begin
        e.busy = 1; e.en = 0; e.we = 0;
      end else if (mask == 8'hFF) begin
        e.busy = 1; e.en = 1; e.we = 1;
      end else begin
        e.busy = 3; e.en = 2; e.we = 1;
      end
      if (!oor) begin
        m64 = '0;
        for (int b = 0; b < 8; b++) if (mask[b]) m64 = m64 | (64'hFF << (8 * b));
        ref_mem[a] = (data & m64) | (ref_mem[a] & ~m64);
      end
    end
    exp_q.push_back(e);
    ram_re = re; ram_we = we; ram_addr = addr; ram_dout = data; ram_mask = mask;
    @(posedge clk); #1;
    if (junk) begin
      ram_re   = 1'b1;
      ram_we   = 1'($urandom);
      ram_addr = 28'($urandom_range(0, DEPTH - 1));
      ram_dout = {$urandom, $urandom};
      ram_mask = 8'($urandom);
      repeat (e.busy) @(posedge clk);
      #1;
    end
    ram_re = 1'b0; ram_we = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  m;
    logic [27:0] ad;
    int          sel, n;
    rst = 1'b0; ram_re = 0; ram_we = 0; ram_addr = '0; ram_dout = '0; ram_mask = '0;
    last_din = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = {$urandom, $urandom};
      if (i == 5) d = 64'h0011223344556677;
      if (i == 7) d = 64'h1111111111111111;
      ref_mem[i] = d;
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = AW'(i); pl_data = d;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;

    // Reset values
    chk("rst_ready", 64'(ram_ready), 64'd1);
    chk("rst_din",   ram_din, 64'd0);
    chk("rst_err",   64'(ram_err), 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_sram_we", 64'(sram_we), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_sram_wdata", sram_wdata, 64'd0);
    rst = 1'b1;

    // Directed scenarios
    do_op(1, 0, 28'd5, 64'd0, 8'hFF, 0);
    do_op(0, 1, 28'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, 0);
    do_op(1, 0, 28'd3, 64'd0, 8'hFF, 0);
    do_op(0, 1, 28'd7, 64'hAAAAAAAABBBBBBBB, 8'h0F, 0);
    do_op(1, 0, 28'd7, 64'd0, 8'hFF, 0);
    do_op(1, 0, 28'd300, 64'd0, 8'hFF, 0);
    do_op(0, 1, 28'd300, 64'h0123456789ABCDEF, 8'hFF, 0);
    do_op(0, 1, 28'd301, 64'h0123456789ABCDEF, 8'h3C, 0);
    do_op(1, 0, 28'd44, 64'd0, 8'hFF, 0);
    do_op(1, 1, 28'd5, 64'h5555555555555555, 8'hFF, 0);
    do_op(1, 0, 28'd5, 64'd0, 8'hFF, 0);
    do_op(0, 1, 28'd10, 64'h9999999999999999, 8'h00, 0);
    do_op(1, 0, 28'd20, 64'd0, 8'hFF, 1);
    do_op(0, 1, 28'd21, 64'h7777777777777777, 8'h3C, 1);
    do_op(0, 1, 28'd22, 64'h6666666666666666, 8'hFF, 1);

    // Reset asserted while a partial write to word 9 is in its merge cycle
    wait_ready();
    ram_we = 1'b1; ram_addr = 28'd9; ram_dout = 64'hCCCCCCCCCCCCCCCC; ram_mask = 8'h33;
    @(posedge clk); #1;
    ram_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", 64'(ram_ready), 64'd1);
    chk("abort_din",   ram_din, 64'd0);
    chk("abort_err",   64'(ram_err), 64'd0);
    chk("abort_sram_en", 64'(sram_en), 64'd0);
    chk("abort_sram_we", 64'(sram_we), 64'd0);
    chk("abort_sram_addr", 64'(sram_addr), 64'd0);
    chk("abort_sram_wdata", sram_wdata, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    last_din = '0;
    chk("word9_after_abort", sram_mem[9], ref_mem[9]);
    do_op(1, 0, 28'd9, 64'd0, 8'hFF, 0);

    // Randomised traffic
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) ad = 28'($urandom_range(DEPTH, 32'h0FFF_FFFF));
      else                          ad = 28'($urandom_range(0, DEPTH - 1));
      sel = $urandom_range(0, 5);
      m = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      d = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      do_op(sel <= 1, sel >= 1, ad, d, m, $urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) fail_note("drain_timeout");
    @(posedge clk); #1;

    for (int i = 0; i < int'(DEPTH); i++) chk("final_mem", sram_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
